roi_quad_config_ctrl: RTL
=========================

// Module: roi_quad_config_ctrl
// PURPOSE
//  Run-time configuration controller for the quadrilateral ROI masking stage of the video pipeline.
//  Holds the four vertex registers, written over a simple register port.
//  Converts the vertices into per-edge line coefficients (A*x + B*y + C) using one shared multiplier.
//  Swaps the coefficients in atomically at frame boundaries, so the mask never changes mid-frame.
// PARAMETERS
//  IMAGE_WIDTH  640  active pixels per line; bound for X vertices
//  IMAGE_HEIGHT 480  active lines per frame; bound for Y vertices
//  COORD_W      16   vertex register width (unsigned)
//  DEF_P1_X/Y   210/250, DEF_P2_X/Y 12/479, DEF_P3_X/Y 410/479, DEF_P4_X/Y 380/252  reset vertex values (CCW)
// PORTS
//  aclk          in   1           single clock
//  aresetn       in   1           asynchronous, active-low reset
//  cfg_wr_en     in   1           register write strobe; accepted only when cfg_ready=1
//  cfg_addr      in   3           0..7 = P1_X,P1_Y,P2_X,P2_Y,P3_X,P3_Y,P4_X,P4_Y
//  cfg_wdata     in   COORD_W     write data
//  cfg_commit    in   1           1-cycle pulse: compute and stage the current vertices
//  cfg_ready     out  1           1 when IDLE or PEND (writes/commit accepted)
//  cfg_error     out  1           sticky: last commit rejected (vertex out of bounds)
//  frame_end     in   1           pulse on fire of last pixel of a frame (tlast && last line)
//  roi_valid     out  1           active coefficient set is valid; 0 -> datapath masks all pixels
//  edge_a        out  4*17        signed A_i = -(Y_{i+1}-Y_i), edge i in bits [17i+:17]
//  edge_b        out  4*17        signed B_i =  (X_{i+1}-X_i)
//  edge_c        out  4*36        signed C_i = (Y_{i+1}-Y_i)*X_i - (X_{i+1}-X_i)*Y_i
// BEHAVIOUR
//  Reset (async): vertices <= DEF_*; roi_valid, cfg_error, edge_* <= 0; state <= CALC (auto-commit of defaults).
//  Pixel is inside iff A_i*x + B_i*y + C_i <= 0 for all i. Edge i runs P_i -> P_{i+1}; P4 wraps to P1.
//  States: IDLE, CHECK, CALC, PEND.
//  - IDLE: cfg_ready=1; writes update vertex regs next edge; cfg_commit -> CHECK.
//  - CHECK (1 cycle): any X >= IMAGE_WIDTH or Y >= IMAGE_HEIGHT -> cfg_error=1, back to IDLE, staged set untouched.
//    Otherwise cfg_error=0 -> CALC.
//  - CALC: 8 cycles, 2 per edge (phase0 dY*X_i, phase1 dX*Y_i). One 17x17 signed multiplier, registered output.
//    A/B/C written into the staging set; cfg_ready=0; writes and commits ignored (no side effects). -> PEND.
//  - PEND: staging set complete, cfg_ready=1.
//    frame_end -> active <= staging, roi_valid <= 1 on that edge -> IDLE.
//    Writes are allowed and do not disturb staging. cfg_commit -> CHECK, replacing the pending set.
//  Simultaneous frame_end + cfg_commit in PEND: apply the existing staging set, then go to CHECK for the new one.
//  frame_end outside PEND: no effect. Active outputs change only on a frame_end edge.
//  First frame_end sampled in PEND applies; first pixel of the next frame sees new coefficients.
//  Commit-to-staged latency: 1 (CHECK) + 8 (CALC) = 9 cycles.
//  Arithmetic: all differences sign-extended to 17 bits before multiply; C = 36-bit signed subtraction, no saturation.
//  cfg_wr_en with cfg_addr in range is the only write path; same-cycle wr_en + commit writes first, then CHECK sees new value.
//  Reset asserted mid-CALC/PEND: pending set discarded; outputs return to reset values immediately.
// STRUCTURE
//  Shared package roi_pkg: COORD_W, EDGE_AB_W=17, EDGE_C_W=36, state encoding, cfg address constants.
//  One sub-module, roi_edge_coef_mac: time-shared multiplier plus subtract, producing one edge per 2 cycles.
//  Vertex regs, FSM and staging/active banks live in the top.
// TESTING
//  Reset release, then frame_end at cycle 20 -> roi_valid=1;
//   edge0 A=-229, B=-198, C=97590; edge1 A=0, B=398, C=-190642 (dY=0, dX=398, Y=479).
//  Write P1_X=700, commit -> cfg_error=1 after 1 cycle, state IDLE; active coefficients unchanged across frame_end.
//  Commit new quad (0,0),(0,479),(639,479),(639,0) mid-frame -> outputs unchanged until frame_end;
//   then edge0 A=-479, B=0, C=0.
//  Writes and commits during CALC -> ignored, cfg_ready=0 for exactly 8 cycles, vertex regs unchanged.
//  frame_end and cfg_commit in the same PEND cycle -> old staging applied, new set applied at the following frame_end.
//  Assert aresetn low in PEND -> roi_valid=0 and edge_*=0 asynchronously; defaults are recomputed after release.

Source files
------------

// File: rtl/roi_pkg.sv
// roi_pkg: shared widths, FSM encoding and register map
// for the quadrilateral ROI configuration controller.
package roi_pkg;

  localparam int COORD_W   = 16;
  localparam int EDGE_AB_W = 17;
  localparam int EDGE_C_W  = 36;
  localparam int MUL_W     = 2 * EDGE_AB_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;
  localparam logic [1:0] ST_PEND  = 2'd3;

  localparam logic [2:0] ADDR_P1_X = 3'd0;
  localparam logic [2:0] ADDR_P1_Y = 3'd1;
  localparam logic [2:0] ADDR_P2_X = 3'd2;
  localparam logic [2:0] ADDR_P2_Y = 3'd3;
  localparam logic [2:0] ADDR_P3_X = 3'd4;
  localparam logic [2:0] ADDR_P3_Y = 3'd5;
  localparam logic [2:0] ADDR_P4_X = 3'd6;
  localparam logic [2:0] ADDR_P4_Y = 3'd7;

  typedef logic signed [EDGE_AB_W-1:0] coef_ab_t;
  typedef logic signed [EDGE_C_W-1:0]  coef_c_t;

endpackage

// File: rtl/roi_edge_coef_mac.sv
// roi_edge_coef_mac: one shared 17x17 signed multiplier,
// phase0 dY*X_i into a register, phase1 C = dY*X_i - dX*Y_i.
module roi_edge_coef_mac
  import roi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               phase,
  input  logic [COORD_W-1:0] xi,
  input  logic [COORD_W-1:0] yi,
  input  logic [COORD_W-1:0] xn,
  input  logic [COORD_W-1:0] yn,
  output coef_ab_t           a,
  output coef_ab_t           b,
  output coef_c_t            c
);

  coef_ab_t dx;
  coef_ab_t dy;
  coef_ab_t op_m;
  coef_ab_t op_v;
  logic signed [MUL_W-1:0] prod;
  coef_c_t p_q;
  coef_c_t p_d;

  always_comb begin
    dx   = $signed({1'b0, xn}) - $signed({1'b0, xi});
    dy   = $signed({1'b0, yn}) - $signed({1'b0, yi});
    op_m = phase ? dx : dy;
    op_v = phase ? $signed({1'b0, yi})
                 : $signed({1'b0, xi});
    prod = op_m * op_v;
    p_d  = (en && !phase) ? EDGE_C_W'(prod) : p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  end

  assign a = -dy;
  assign b = dx;
  assign c = p_q - EDGE_C_W'(prod);

endmodule

// File: rtl/roi_quad_config_ctrl.sv
// roi_quad_config_ctrl: vertex registers, bounds check, edge
// coefficient computation and frame-synchronous bank swap.
module roi_quad_config_ctrl
  import roi_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter logic [COORD_W-1:0] DEF_P1_X = 16'd210,
  parameter logic [COORD_W-1:0] DEF_P1_Y = 16'd250,
  parameter logic [COORD_W-1:0] DEF_P2_X = 16'd12,
  parameter logic [COORD_W-1:0] DEF_P2_Y = 16'd479,
  parameter logic [COORD_W-1:0] DEF_P3_X = 16'd410,
  parameter logic [COORD_W-1:0] DEF_P3_Y = 16'd479,
  parameter logic [COORD_W-1:0] DEF_P4_X = 16'd380,
  parameter logic [COORD_W-1:0] DEF_P4_Y = 16'd252
)(
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cfg_wr_en,
  input  logic [2:0]             cfg_addr,
  input  logic [COORD_W-1:0]     cfg_wdata,
  input  logic                   cfg_commit,
  output logic                   cfg_ready,
  output logic                   cfg_error,
  input  logic                   frame_end,
  output logic                   roi_valid,
  output logic [4*EDGE_AB_W-1:0] edge_a,
  output logic [4*EDGE_AB_W-1:0] edge_b,
  output logic [4*EDGE_C_W-1:0]  edge_c
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(IMAGE_WIDTH);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(IMAGE_HEIGHT);

  logic [1:0] st_q, st_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0][COORD_W-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [3:0][EDGE_AB_W-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [3:0][EDGE_AB_W-1:0] aa_q, aa_d, ab_q, ab_d;
  logic [3:0][EDGE_C_W-1:0] sc_q, sc_d, ac_q, ac_d;
  logic err_q, err_d, vld_q, vld_d;
  logic oob, ready;
  logic [1:0] ei, ni;
  coef_ab_t ca, cb;
  coef_c_t cc;

  assign ei    = cnt_q[2:1];
  assign ni    = ei + 2'd1;
  assign ready = (st_q == ST_IDLE) || (st_q == ST_PEND);

  roi_edge_coef_mac u_mac (
    .clk   (aclk),
    .rst_n (aresetn),
    .en    (st_q == ST_CALC),
    .phase (cnt_q[0]),
    .xi    (vx_q[ei]),
    .yi    (vy_q[ei]),
    .xn    (vx_q[ni]),
    .yn    (vy_q[ni]),
    .a     (ca),
    .b     (cb),
    .c     (cc)
  );

  always_comb begin
    oob = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (vx_q[i] >= X_LIM || vy_q[i] >= Y_LIM) oob = 1'b1;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    vx_d  = vx_q;
    vy_d  = vy_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    sc_d  = sc_q;
    aa_d  = aa_q;
    ab_d  = ab_q;
    ac_d  = ac_q;
    err_d = err_q;
    vld_d = vld_q;
    if (ready && cfg_wr_en) begin
      case (cfg_addr)
        ADDR_P1_X: vx_d[0] = cfg_wdata;
        ADDR_P1_Y: vy_d[0] = cfg_wdata;
        ADDR_P2_X: vx_d[1] = cfg_wdata;
        ADDR_P2_Y: vy_d[1] = cfg_wdata;
        ADDR_P3_X: vx_d[2] = cfg_wdata;
        ADDR_P3_Y: vy_d[2] = cfg_wdata;
        ADDR_P4_X: vx_d[3] = cfg_wdata;
        ADDR_P4_Y: vy_d[3] = cfg_wdata;
      endcase
    end
    case (st_q)
      ST_IDLE: begin
        if (cfg_commit) st_d = ST_CHECK;
      end
      ST_CHECK: begin
        err_d = oob;
        cnt_d = '0;
        st_d  = oob ? ST_IDLE : ST_CALC;
      end
      ST_CALC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q[0]) begin
          sa_d[ei] = ca;
          sb_d[ei] = cb;
          sc_d[ei] = cc;
        end
        if (cnt_q == 3'd7) st_d = ST_PEND;
      end
      ST_PEND: begin
        // apply before a same-cycle commit restarts the pipeline
        if (frame_end) begin
          aa_d  = sa_q;
          ab_d  = sb_q;
          ac_d  = sc_q;
          vld_d = 1'b1;
        end
        if (cfg_commit)     st_d = ST_CHECK;
        else if (frame_end) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st_q  <= ST_CALC;
      cnt_q <= '0;
      vx_q  <= {DEF_P4_X, DEF_P3_X, DEF_P2_X, DEF_P1_X};
      vy_q  <= {DEF_P4_Y, DEF_P3_Y, DEF_P2_Y, DEF_P1_Y};
      sa_q  <= '0;
      sb_q  <= '0;
      sc_q  <= '0;
      aa_q  <= '0;
      ab_q  <= '0;
      ac_q  <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      vx_q  <= vx_d;
      vy_q  <= vy_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      sc_q  <= sc_d;
      aa_q  <= aa_d;
      ab_q  <= ab_d;
      ac_q  <= ac_d;
      err_q <= err_d;
      vld_q <= vld_d;
    end
  end

  assign cfg_ready = ready;
  assign cfg_error = err_q;
  assign roi_valid = vld_q;
  assign edge_a    = aa_q;
  assign edge_b    = ab_q;
  assign edge_c    = ac_q;

endmodule
